// File: rtl/doorlock_pkg.sv
// ============================================================================
// doorlock_pkg: shared key constants, FSM encoding and key-vector helpers.
// Revision: 1.0
// ============================================================================
`default_nettype none

package doorlock_pkg;

  localparam int NUM_KEYS = 11;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_NONE = 4'hF;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } key_state_t;

  // Exactly one bit set: non-zero with the lowest set bit being the only one.
  function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
    return (v != '0) && ((v & (v - 11'd1)) == '0);
  endfunction

  // OR of the indices of all set bits; exact only when the vector is one-hot,
  // which is the only case in which the result is used.
  function automatic logic [3:0] key_index(input logic [NUM_KEYS-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_debounce_vec.sv
// ============================================================================
// sync_debounce_vec: 2-FF synchroniser plus whole-vector debounce.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_debounce_vec #(
  parameter int          WIDTH  = 11,
  parameter logic [19:0] T_20MS = 20'hF_4240
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] db
);

  localparam logic [19:0] CNT_MAX = T_20MS - 20'd1;

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] cand_q,  cand_d;
  logic [WIDTH-1:0] db_q,    db_d;
  logic [19:0]      cnt_q,   cnt_d;

  // Any bit change restarts the count for the whole vector; once the count
  // saturates the candidate is published and the counter parks there.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 20'd1;
    end else begin
      db_d = cand_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      db_q    <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
    end
  end

  assign db = db_q;

endmodule

`default_nettype wire

// File: rtl/key_input_conditioner.sv
// ============================================================================
// key_input_conditioner: debounced keypad front end emitting single-cycle
// key_valid / key_err events for the doorlock FSM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module key_input_conditioner
  import doorlock_pkg::*;
#(
  parameter logic [19:0] T_20MS = 20'hF_4240
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [9:0]          bt,
  input  logic                btstar,
  output logic                key_valid,
  output logic [3:0]          key_code,
  output logic                key_star,
  output logic                key_err,
  output logic                key_busy,
  output logic [NUM_KEYS-1:0] key_db
);

  logic [NUM_KEYS-1:0] raw;
  logic [NUM_KEYS-1:0] db;
  logic                one_hot;
  logic                any_key;
  logic [3:0]          enc_code;

  key_state_t state_q, state_d;
  logic       valid_q, valid_d;
  logic       err_q,   err_d;
  logic       star_q,  star_d;
  logic [3:0] code_q,  code_d;

  // Star is active-low at the pin; flip it so the whole vector is active-high.
  assign raw = {~btstar, bt};

  sync_debounce_vec #(
    .WIDTH  (NUM_KEYS),
    .T_20MS (T_20MS)
  ) u_sync_debounce_vec (
    .clk (clk),
    .rst (rst),
    .raw (raw),
    .db  (db)
  );

  assign one_hot  = is_onehot(db);
  assign any_key  = |db;
  assign enc_code = key_index(db);

  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    star_d  = 1'b0;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        if (any_key) begin
          state_d = HELD;
          if (one_hot) begin
            valid_d = 1'b1;
            code_d  = enc_code;
            star_d  = (enc_code == KEY_STAR);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      HELD: begin
        // Extra keys or partial releases are ignored until everything is up.
        if (!any_key) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      star_q  <= 1'b0;
      code_q  <= KEY_NONE;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      star_q  <= star_d;
      code_q  <= code_d;
    end
  end

  assign key_valid = valid_q;
  assign key_err   = err_q;
  assign key_star  = star_q;
  assign key_code  = code_q;
  assign key_busy  = (state_q == HELD);
  assign key_db    = db;

endmodule

`default_nettype wire

// File: tb/tb_key_input_conditioner.sv
// ============================================================================
// tb_key_input_conditioner: table-driven presses plus corner-case sequences,
// with expected key events queued at drive time and popped as they appear.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_key_input_conditioner;

  localparam int LAT = 12;  // input edge to event, T_20MS = 8

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  bt = '0;
  logic        btstar = 1'b1;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_star;
  logic        key_err;
  logic        key_busy;
  logic [10:0] key_db;

  key_input_conditioner #(
    .T_20MS (20'h000_0008)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bt        (bt),
    .btstar    (btstar),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_star  (key_star),
    .key_err   (key_err),
    .key_busy  (key_busy),
    .key_db    (key_db)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic       err;
    logic [3:0] code;
    int         due;
  } ev_t;

  ev_t        evq[$];
  ev_t        ev;
  logic [3:0] last_code = 4'hF;

  typedef struct {
    logic [10:0] keys;
    logic        err;
    logic [3:0]  code;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_keys(input logic [10:0] k);
    bt     = k[9:0];
    btstar = ~k[10];
  endtask

  task automatic expect_ev(input logic err, input logic [3:0] code);
    ev_t e;
    e.err  = err;
    e.code = code;
    e.due  = cyc + LAT;
    evq.push_back(e);
  endtask

  // Scoreboard: every event seen must match the head of the queue in kind,
  // code and exact cycle; an overdue head is reported as missing.
  always @(negedge clk) begin
    if (!rst) begin
      if (evq.size() > 0 && evq[0].due < cyc) begin
        compared++;
        mismatched++;
        $display("FAIL missing_event: got none expected code %0d err %0b due %0d (cycle %0d)",
                 evq[0].code, evq[0].err, evq[0].due, cyc);
        void'(evq.pop_front());
      end
      if (key_valid || key_err) begin
        check("valid_err_exclusive", {31'd0, key_valid & key_err}, 32'd0);
        if (evq.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_event: got valid %0b err %0b code %0d expected none (cycle %0d)",
                   key_valid, key_err, key_code, cyc);
        end else begin
          ev = evq.pop_front();
          check("event_kind_err", {31'd0, key_err}, {31'd0, ev.err});
          check("event_cycle", cyc, ev.due);
          if (!ev.err) begin
            check("event_code", {28'd0, key_code}, {28'd0, ev.code});
            last_code = ev.code;
          end else begin
            check("err_code_hold", {28'd0, key_code}, {28'd0, last_code});
          end
          check("key_star", {31'd0, key_star},
                {31'd0, (!ev.err && ev.code == 4'd10)});
        end
      end
    end
  end

  task automatic check_drained(input string name);
    check(name, evq.size(), 0);
    evq.delete();
  endtask

  initial begin
    for (int i = 0; i < 11; i++) begin
      tbl[i].keys = 11'd1 << i;
      tbl[i].err  = 1'b0;
      tbl[i].code = 4'(i);
    end
    tbl[11] = '{keys: 11'h084, err: 1'b1, code: 4'h0};
    tbl[12] = '{keys: 11'h401, err: 1'b1, code: 4'h0};
    tbl[13] = '{keys: 11'h7FF, err: 1'b1, code: 4'h0};

    rst = 1'b1;
    tick(3);
    check("rst_valid", {31'd0, key_valid}, 32'd0);
    check("rst_err",   {31'd0, key_err},   32'd0);
    check("rst_star",  {31'd0, key_star},  32'd0);
    check("rst_busy",  {31'd0, key_busy},  32'd0);
    check("rst_db",    {21'd0, key_db},    32'd0);
    check("rst_code",  {28'd0, key_code},  32'h0000_000F);
    rst = 1'b0;
    tick(5);

    // Single keys, then multi-key presses that must raise key_err.
    for (int i = 0; i < 14; i++) begin
      set_keys(tbl[i].keys);
      expect_ev(tbl[i].err, tbl[i].code);
      tick(20);
      check("tbl_db", {21'd0, key_db}, {21'd0, tbl[i].keys});
      check("tbl_busy_held", {31'd0, key_busy}, 32'd1);
      set_keys('0);
      tick(10);
      check("tbl_busy_release_pending", {31'd0, key_busy}, 32'd1);
      tick(2);
      check("tbl_busy_release", {31'd0, key_busy}, 32'd0);
      check("tbl_db_release", {21'd0, key_db}, 32'd0);
      tick(4);
      check("tbl_code_hold", {28'd0, key_code}, {28'd0, last_code});
      check_drained("tbl_drained");
    end

    // Star glitches shorter than the stability time, then a real press.
    set_keys(11'h400); tick(2);
    set_keys('0);      tick(1);
    set_keys(11'h400); tick(3);
    set_keys('0);      tick(1);
    set_keys(11'h400);
    expect_ev(1'b0, 4'd10);
    tick(20);
    set_keys('0);
    tick(16);
    check_drained("star_glitch_drained");

    // Overlap: second key while first is held is ignored; alone it counts.
    set_keys(11'h002);
    expect_ev(1'b0, 4'd1);
    tick(15);
    set_keys(11'h022);
    tick(12);
    check("overlap_db", {21'd0, key_db}, 32'h0000_0022);
    set_keys('0);
    tick(20);
    set_keys(11'h020);
    expect_ev(1'b0, 4'd5);
    tick(20);
    set_keys('0);
    tick(16);
    check_drained("overlap_drained");

    // Contact bounce on bt[4], then settled high.
    for (int k = 0; k < 10; k++) begin
      set_keys((k % 2 == 0) ? 11'h010 : 11'h000);
      tick(3);
    end
    set_keys(11'h010);
    expect_ev(1'b0, 4'd4);
    tick(20);
    set_keys('0);
    tick(16);
    check_drained("bounce_drained");

    // Reset mid-count with bt[3] held across the reset.
    set_keys(11'h008);
    tick(8);
    rst = 1'b1;
    #1;
    check("midrst_valid", {31'd0, key_valid}, 32'd0);
    check("midrst_err",   {31'd0, key_err},   32'd0);
    check("midrst_busy",  {31'd0, key_busy},  32'd0);
    check("midrst_db",    {21'd0, key_db},    32'd0);
    check("midrst_code",  {28'd0, key_code},  32'h0000_000F);
    last_code = 4'hF;
    tick(2);
    rst = 1'b0;
    expect_ev(1'b0, 4'd3);
    tick(20);
    set_keys('0);
    tick(16);
    check_drained("midrst_drained");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
